// File: rtl/scanmux_secure_select_ctrl_if.sv
// IJTAG scan-port bundle for the secure select controller: the select/enable
// strobes and scan data in from the network, and scan data out back to it.
interface scanmux_secure_select_ctrl_if;
    logic ijtag_sel;
    logic ijtag_ce;
    logic ijtag_se;
    logic ijtag_ue;
    logic ijtag_si;
    logic ijtag_so;

    modport master (
        output ijtag_sel,
        output ijtag_ce,
        output ijtag_se,
        output ijtag_ue,
        output ijtag_si,
        input  ijtag_so
    );

    modport slave (
        input  ijtag_sel,
        input  ijtag_ce,
        input  ijtag_se,
        input  ijtag_ue,
        input  ijtag_si,
        output ijtag_so
    );
endinterface

// File: rtl/scanmux_secure_select_ctrl.sv
// Keyed IJTAG CSU register that opens a secure scan mux only with the right key.
// Optional macro SCANMUX_SECURE_LOCK_CLOSE_EN: lockout also forces the mux closed.
module scanmux_secure_select_ctrl #(
    parameter int               KEY_W     = 16,
    parameter logic [KEY_W-1:0] KEY_VALUE = 16'hA5C3,
    parameter int               MAX_FAIL  = 3
) (
    input  logic                               ijtag_tck,
    input  logic                               ijtag_reset,
    scanmux_secure_select_ctrl_if.slave        scan,
    output logic                               mux_select,
    output logic                               locked,
    output logic [2:0]                         fail_count
);

    typedef enum logic [1:0] {
        OP_NONE,
        OP_CAPTURE,
        OP_SHIFT,
        OP_UPDATE
    } op_e;

    localparam logic [2:0] FAIL_LIMIT = 3'(MAX_FAIL);

    logic [KEY_W:0] sr_q;
    logic [KEY_W:0] sr_d;
    logic           mux_select_q;
    logic           mux_select_d;
    logic           locked_q;
    logic           locked_d;
    logic [2:0]     fail_count_q;
    logic [2:0]     fail_count_d;

    op_e            op;
    logic           key_match;
    logic [2:0]     fail_next;

    // One op per selected cycle; capture wins over shift, shift over update.
    always_comb begin
        op = OP_NONE;
        if (scan.ijtag_sel) begin
            if (scan.ijtag_ce) begin
                op = OP_CAPTURE;
            end else if (scan.ijtag_se) begin
                op = OP_SHIFT;
            end else if (scan.ijtag_ue) begin
                op = OP_UPDATE;
            end
        end
    end

    assign key_match = (sr_q[KEY_W-1:0] == KEY_VALUE);
    assign fail_next = fail_count_q + 3'd1;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case infers a latch.
        sr_d         = sr_q;
        mux_select_d = mux_select_q;
        locked_d     = locked_q;
        fail_count_d = fail_count_q;

        case (op)
            OP_CAPTURE: begin
                // Key field captures as zeros so the stored key is never scanned out.
                sr_d = {mux_select_q, {KEY_W{1'b0}}};
            end
            OP_SHIFT: begin
                sr_d = {scan.ijtag_si, sr_q[KEY_W:1]};
            end
            OP_UPDATE: begin
                if (!locked_q) begin
                    if (!sr_q[KEY_W]) begin
                        mux_select_d = 1'b0;
                    end else if (key_match) begin
                        mux_select_d = 1'b1;
                        fail_count_d = 3'd0;
                    end else begin
                        fail_count_d = fail_next;
                        if (fail_next == FAIL_LIMIT) begin
                            locked_d = 1'b1;
`ifdef SCANMUX_SECURE_LOCK_CLOSE_EN
                            mux_select_d = 1'b0;
`else
                            mux_select_d = mux_select_q;
`endif
                        end
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge ijtag_tck) begin
        // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
        if (ijtag_reset) begin
            sr_q         <= '0;
            mux_select_q <= 1'b0;
            locked_q     <= 1'b0;
            fail_count_q <= 3'd0;
        end else begin
            sr_q         <= sr_d;
            mux_select_q <= mux_select_d;
            locked_q     <= locked_d;
            fail_count_q <= fail_count_d;
        end
    end

    assign scan.ijtag_so = sr_q[0];
    assign mux_select    = mux_select_q;
    assign locked        = locked_q;
    assign fail_count    = fail_count_q;

endmodule

// File: doc/scanmux_secure_select_ctrl.md
Name: scanmux_secure_select_ctrl

Overview:
- Keyed IJTAG select controller for one secure scan mux, such as the intest/EDT bi-solution mux in the gate ijtag instrument.
- Holds the mux_select bit in a capture/shift/update (CSU) data register.
- Opening the mux requires a matching key. Closing it is always allowed.
- Repeated wrong keys drive a sticky lockout.
- Sits in the IJTAG network beside the mux. It drives mux_select, and its scan cell chains through ijtag_si/ijtag_so.

Parameters:
- KEY_W, 16: key width in bits. Shift register length is KEY_W+1.
- KEY_VALUE, 16'hA5C3: unlock key compared at update.
- MAX_FAIL, 3: number of consecutive bad-key updates that sets locked. Legal range 1..7.

Ports:
- ijtag_tck, input, 1: clock. All state changes on its rising edge.
- ijtag_reset, input, 1: reset, synchronous, active-high.
- ijtag_sel, input, 1: this register is on the active scan path. Gates ce, se and ue.
- ijtag_ce, input, 1: capture enable.
- ijtag_se, input, 1: shift enable.
- ijtag_ue, input, 1: update enable.
- ijtag_si, input, 1: scan in.
- ijtag_so, output, 1: scan out. Equals sr[0] combinationally.
- mux_select, output, 1: drives the scan mux select. 1 = instrument path.
- locked, output, 1: sticky lockout flag.
- fail_count, output, 3: consecutive bad-key count.

Behaviour:
- Reset:
  - Applied when ijtag_reset=1 at a rising edge. Overrides every other input in that cycle.
  - Clears sr (KEY_W+1 bits), mux_select, locked and fail_count to 0. ijtag_so therefore reads 0.
- Op select:
  - Each cycle with ijtag_sel=1, at most one op runs. Priority is ce > se > ue.
  - With ijtag_sel=0, sr, mux_select, locked and fail_count hold.
- Capture: sr <= {mux_select, KEY_W'b0}. The key field is never read back, so secrets are not observable on so.
- Shift:
  - sr <= {ijtag_si, sr[KEY_W:1]}, LSB exits first.
  - After KEY_W+1 shifts, the first bit shifted in sits in sr[0] and the last sits in sr[KEY_W] (the select bit).
- Update: uses the sr value present in that cycle. Evaluated in this order:
  1. locked=1: no change to any state.
  2. sr[KEY_W]=0: mux_select <= 0. fail_count unchanged. Close needs no key.
  3. sr[KEY_W]=1 and sr[KEY_W-1:0]==KEY_VALUE: mux_select <= 1, fail_count <= 0.
  4. sr[KEY_W]=1 with key mismatch: mux_select unchanged, fail_count <= fail_count+1. If fail_count+1 == MAX_FAIL, locked <= 1 in the same edge.
- Update never alters sr.
- Outputs change exactly one cycle after the update edge. No pipelining.
- fail_count saturates at MAX_FAIL. It cannot wrap because a locked controller ignores updates.
- Re-opening with the correct key while mux_select=1 is legal: fail_count clears, mux_select stays 1.
- Reset asserted mid-shift discards the partial key. The next op starts from sr=0.

Optional Feature:
- Macro: SCANMUX_SECURE_LOCK_CLOSE_EN.
- Defined: the edge that sets locked also forces mux_select <= 0. While locked=1, mux_select is held at 0.
- Undefined: mux_select keeps its pre-lock value through lockout. Only reset clears it.

Test Plan:
- Reset: assert reset with prior mux_select=1 and sr nonzero -> next cycle mux_select=0, locked=0, fail_count=0, ijtag_so=0.
- Unlock: shift 17 bits (key 16'hA5C3 LSB-first, then 1), pulse ue -> mux_select=1, fail_count=0. A following capture plus 17 shifts returns 16 zeros then 1 on so.
- Close without key: shift 17 bits of {0, 16'h0000}, pulse ue -> mux_select 1->0, fail_count unchanged.
- Lockout: three updates with {1, 16'h1234} -> fail_count goes 1, 2, then locked=1 and fail_count=3. A fourth update with the correct key leaves mux_select unchanged and locked=1. Check under both macro settings (mux_select=0 when defined; pre-lock value when undefined).
- Priority/gating:
  - ce=se=ue=1 with sel=1 -> only capture occurs.
  - Same ops with sel=0 -> no state change; so is still sr[0].
- Fail reset by success: two bad updates (fail_count=2), then correct key -> mux_select=1, fail_count=0, locked stays 0.
